// File: rtl/mano_reg_ar_if.sv
// Bus bundle for the Mano-style address register.
// The controller drives the selects and data; the register returns AR.
interface mano_reg_ar_if;
    logic [15:0] IN_IR;
    logic [15:0] IN;
    logic [2:0]  t;
    logic [15:0] Q_AR;

    modport master (
        output IN_IR,
        output IN,
        output t,
        input  Q_AR
    );

    modport slave (
        input  IN_IR,
        input  IN,
        input  t,
        output Q_AR
    );
endinterface

// File: rtl/mano_reg_ar.sv
// 12-bit address register (AR) of the Mano basic computer.
// Loads from PC/bus or IR address, increments, or holds; output zero-extended.
module mano_reg_ar (
    input  logic           CLK,
    input  logic           RST_N,
    mano_reg_ar_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_FETCH  = 3'b000,
        OP_DECODE = 3'b010,
        OP_BUS    = 3'b011,
        OP_INC    = 3'b100
    } ar_op_e;

    logic [11:0] ar_q;
    logic [11:0] ar_d;

    // Upper nibbles of both sources are address-irrelevant by design.
    logic [7:0] unused_upper;
    assign unused_upper = {bus.IN_IR[15:12], bus.IN[15:12]};

    // Only one operation per cycle; X/Z or unassigned codes fall to hold.
    always_comb begin
        // NOTE: default assigned first so every path drives ar_d -> no latch.
        ar_d = ar_q;
        case (bus.t)
            OP_FETCH:  ar_d = bus.IN[11:0];
            OP_DECODE: ar_d = bus.IN_IR[11:0];
            OP_BUS:    ar_d = bus.IN[11:0];
            OP_INC:    ar_d = ar_q + 12'd1;
            default:   ar_d = ar_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ar_q <= 12'h000;
        end else begin
            // NOTE: non-blocking so the register samples the pre-edge value.
            ar_q <= ar_d;
        end
    end

    assign bus.Q_AR = {4'h0, ar_q};

endmodule

// File: tb/tb_mano_reg_ar.sv
// Directed self-checking bench for mano_reg_ar.
// Each task drives one scenario and compares Q_AR against hand-computed values.
module tb_mano_reg_ar;

    logic CLK;
    logic RST_N;
    int   tests_run;
    int   tests_failed;

    mano_reg_ar_if bus_if ();

    mano_reg_ar dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [2:0] t, input logic [15:0] in_v, input logic [15:0] ir_v);
        bus_if.t     = t;
        bus_if.IN    = in_v;
        bus_if.IN_IR = ir_v;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        RST_N = 1'b0;
        drive(3'b000, 16'h1234, 16'h0000);
        #1;
        exp = 16'h0000;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL reset_async: got %h expected %h", bus_if.Q_AR, exp);
        end
        step();
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL reset_clocked: got %h expected %h", bus_if.Q_AR, exp);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        exp = 16'h0234;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: got %h expected %h", bus_if.Q_AR, exp);
        end
    endtask

    task automatic test_decode();
        logic [15:0] exp;
        drive(3'b010, 16'h0000, 16'h5123);
        step();
        exp = 16'h0123;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL decode_load: got %h expected %h", bus_if.Q_AR, exp);
        end
        drive(3'b001, 16'h0FFF, 16'h0FFF);
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (bus_if.Q_AR !== exp) begin
                tests_failed++;
                $display("FAIL hold_001_%0d: got %h expected %h", i, bus_if.Q_AR, exp);
            end
        end
    endtask

    task automatic test_bus_load();
        logic [15:0] exp;
        drive(3'b011, 16'h0000, 16'h5123);
        step();
        exp = 16'h0000;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL bus_load_zero: got %h expected %h", bus_if.Q_AR, exp);
        end
        bus_if.IN = 16'h1234;
        step();
        exp = 16'h0234;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL bus_load_1234: got %h expected %h", bus_if.Q_AR, exp);
        end
    endtask

    task automatic test_increment();
        logic [15:0] exp;
        drive(3'b100, 16'hFFFF, 16'hFFFF);
        step();
        exp = 16'h0235;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL inc_234: got %h expected %h", bus_if.Q_AR, exp);
        end
        drive(3'b000, 16'h0FFF, 16'h0000);
        step();
        exp = 16'h0FFF;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL load_fff: got %h expected %h", bus_if.Q_AR, exp);
        end
        drive(3'b100, 16'h0000, 16'h0000);
        step();
        exp = 16'h0000;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL inc_wrap: got %h expected %h", bus_if.Q_AR, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        drive(3'b000, 16'hF0FE, 16'h0000);
        step();
        drive(3'b100, 16'h0000, 16'h0000);
        exp = 16'h00FE;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = exp + 16'h0001;
            tests_run++;
            if (bus_if.Q_AR !== exp) begin
                tests_failed++;
                $display("FAIL b2b_inc_%0d: got %h expected %h", i, bus_if.Q_AR, exp);
            end
        end
        drive(3'b000, 16'h0100, 16'h0000);
        step();
        drive(3'b100, 16'h0000, 16'h0000);
        step();
        exp = 16'h0101;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL b2b_load_inc: got %h expected %h", bus_if.Q_AR, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp;
        drive(3'b000, 16'h0235, 16'h0000);
        step();
        exp = 16'h0235;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL pre_reset_load: got %h expected %h", bus_if.Q_AR, exp);
        end
        drive(3'b100, 16'h0000, 16'h0000);
        #2;
        RST_N = 1'b0;
        #1;
        exp = 16'h0000;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL mid_cycle_reset: got %h expected %h", bus_if.Q_AR, exp);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (bus_if.Q_AR !== exp) begin
                tests_failed++;
                $display("FAIL reset_ignores_inc_%0d: got %h expected %h", i, bus_if.Q_AR, exp);
            end
        end
        @(negedge CLK);
        drive(3'b000, 16'h0ABC, 16'h0000);
        RST_N = 1'b1;
        step();
        exp = 16'h0ABC;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL post_reset_first_edge: got %h expected %h", bus_if.Q_AR, exp);
        end
    endtask

    task automatic test_hold_codes();
        logic [15:0] exp;
        logic [2:0]  codes [3];
        codes[0] = 3'b101;
        codes[1] = 3'b110;
        codes[2] = 3'b111;
        drive(3'b010, 16'hFFFF, 16'hF0AB);
        step();
        exp = 16'h00AB;
        tests_run++;
        if (bus_if.Q_AR !== exp) begin
            tests_failed++;
            $display("FAIL decode_ignore_upper: got %h expected %h", bus_if.Q_AR, exp);
        end
        for (int i = 0; i < 3; i++) begin
            drive(codes[i], 16'hFFFF, 16'hFFFF);
            step();
            tests_run++;
            if (bus_if.Q_AR !== exp) begin
                tests_failed++;
                $display("FAIL hold_code_%b: got %h expected %h", codes[i], bus_if.Q_AR, exp);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST_N        = 1'b0;
        drive(3'b000, 16'h0000, 16'h0000);
        test_reset();
        test_decode();
        test_bus_load();
        test_increment();
        test_back_to_back();
        test_async_reset();
        test_hold_codes();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
